// File: rtl/mu_axi_pkg.sv
// Shared AXI encodings and a constant-foldable clog2 helper for the mu_axi* blocks.
// No logic, no latency, no backpressure.
package mu_axi_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/mu_ordfifo.sv
// Register FIFO holding the requester index of each outstanding read burst, in issue order.
// Head is combinational (0 cycles); push is ignored when full, pop ignored when empty.
module mu_ordfifo
  import mu_axi_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 1,
  localparam int PW   = clog2(DEPTH),
  localparam int CW   = clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  pop_dat,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          push_ok;
  logic          pop_ok;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_dat  = mem[rptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wptr] <= push_dat;
        wptr      <= wptr + PW'(1);
      end
      if (pop_ok) rptr <= rptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mu_axirdarb.sv
// Round-robin arbiter sharing one AXI4 read channel among NREQ requesters; AR is registered (1 cycle), R is steered combinationally.
// AR stalls while the AR slot is busy or MAXOUT bursts are outstanding; R backpressure from the head requester passes straight to m_rready.
module mu_axirdarb
  import mu_axi_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int AXI_AW  = 32,
  parameter int AXI_DW  = 64,
  parameter int AXI_IDW = 1,
  parameter int MAXOUT  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        s_arvalid,
  output logic [NREQ-1:0]        s_arready,
  input  logic [NREQ*AXI_AW-1:0] s_araddr,
  input  logic [NREQ*8-1:0]      s_arlen,
  input  logic [NREQ*3-1:0]      s_arsize,
  input  logic [NREQ*2-1:0]      s_arburst,
  output logic [NREQ-1:0]        s_rvalid,
  input  logic [NREQ-1:0]        s_rready,
  output logic [AXI_DW-1:0]      s_rdata,
  output logic [1:0]             s_rresp,
  output logic                   s_rlast,
  output logic                   m_arvalid,
  input  logic                   m_arready,
  output logic [AXI_IDW-1:0]     m_arid,
  output logic [AXI_AW-1:0]      m_araddr,
  output logic [7:0]             m_arlen,
  output logic [2:0]             m_arsize,
  output logic [1:0]             m_arburst,
  input  logic                   m_rvalid,
  output logic                   m_rready,
  input  logic [AXI_DW-1:0]      m_rdata,
  input  logic [1:0]             m_rresp,
  input  logic                   m_rlast,
  input  logic [AXI_IDW-1:0]     m_rid,
  output logic                   err_orphan
);

  localparam int IW = clog2(NREQ);
  localparam int CW = clog2(MAXOUT) + 1;

  typedef struct packed {
    logic [AXI_AW-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
  } ar_t;

  logic [IW-1:0] prio_q;
  logic [IW-1:0] win;
  logic [IW:0]   cand;
  logic          found;
  logic          accept;
  ar_t           ar_q;
  ar_t           ar_sel;
  logic [IW-1:0] head;
  logic          ord_full;
  logic          ord_empty;
  logic [CW-1:0] ord_cnt;
  logic          ord_pop;
  logic          unused_rid;

  // Scan from the priority pointer upward, wrapping at NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, prio_q} + (IW+1)'(i);
      if (cand >= (IW+1)'(NREQ)) cand = cand - (IW+1)'(NREQ);
      if (!found && s_arvalid[cand[IW-1:0]]) begin
        found = 1'b1;
        win   = cand[IW-1:0];
      end
    end
  end

  assign accept    = found && (!m_arvalid || m_arready) && (ord_cnt < CW'(MAXOUT));
  assign s_arready = accept ? (NREQ'(1) << win) : '0;

  assign ar_sel.addr  = s_araddr[win*AXI_AW +: AXI_AW];
  assign ar_sel.len   = s_arlen[win*8 +: 8];
  assign ar_sel.size  = s_arsize[win*3 +: 3];
  assign ar_sel.burst = s_arburst[win*2 +: 2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_arvalid <= 1'b0;
      ar_q      <= '0;
      prio_q    <= '0;
    end else if (accept) begin
      m_arvalid <= 1'b1;
      ar_q      <= ar_sel;
      prio_q    <= (win == IW'(NREQ-1)) ? '0 : win + IW'(1);
    end else if (m_arready) begin
      m_arvalid <= 1'b0;
    end
  end

  assign m_arid    = '0;
  assign m_araddr  = ar_q.addr;
  assign m_arlen   = ar_q.len;
  assign m_arsize  = ar_q.size;
  assign m_arburst = ar_q.burst;

  mu_ordfifo #(
    .DEPTH (MAXOUT),
    .W     (IW)
  ) u_ordfifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (accept && !ord_full),
    .push_dat (win),
    .pop      (ord_pop),
    .pop_dat  (head),
    .full     (ord_full),
    .empty    (ord_empty),
    .count    (ord_cnt)
  );

  // A beat with nothing outstanding is held off, never dropped.
  assign s_rvalid = (m_rvalid && !ord_empty) ? (NREQ'(1) << head) : '0;
  assign m_rready = s_rready[head] && !ord_empty;
  assign s_rdata  = m_rdata;
  assign s_rresp  = m_rresp;
  assign s_rlast  = m_rlast;
  assign ord_pop  = m_rvalid && m_rready && m_rlast;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     err_orphan <= 1'b0;
    else if (m_rvalid && ord_empty) err_orphan <= 1'b1;
  end

  assign unused_rid = ^m_rid;

endmodule

// File: doc/mu_axirdarb.md
# mu_axirdarb

Round-robin arbiter that shares one AXI4 read channel (AR + R) among NREQ read requesters, such as the LCD scan-out DMA and future readers like a camera preview or statistics engine. It sits upstream of mu_aximerge's read port. It issues one burst request at a time to the shared master, allows up to MAXOUT bursts in flight, and steers returning R beats to the correct requester. It relies on the in-order return guaranteed for a single AXI ID.

## Interface
Parameters:
- NREQ, 2, number of read requesters (2..8)
- AXI_AW, 32, address width
- AXI_DW, 64, data width
- AXI_IDW, 1, ID width; m_arid is driven constant 0
- MAXOUT, 4, maximum outstanding bursts (power of 2, 2..16)

Ports:
- clk  in  1  system clock; the only clock
- rst_n  in  1  asynchronous, active-low reset
- s_arvalid  in  NREQ  per-requester AR valid
- s_arready  out  NREQ  per-requester AR ready (one-hot or zero)
- s_araddr  in  NREQ*AXI_AW  requester i occupies slice [i*AXI_AW +: AXI_AW]
- s_arlen  in  NREQ*8  burst length per requester
- s_arsize  in  NREQ*3  beat size per requester
- s_arburst  in  NREQ*2  burst type per requester
- s_rvalid  out  NREQ  per-requester R valid (one-hot or zero)
- s_rready  in  NREQ  per-requester R ready
- s_rdata  out  AXI_DW  broadcast to all requesters
- s_rresp  out  2  broadcast
- s_rlast  out  1  broadcast
- m_arvalid, m_arready, m_arid, m_araddr, m_arlen, m_arsize, m_arburst  AXI4 AR master (out/in/out...)
- m_rvalid, m_rready, m_rdata, m_rresp, m_rlast, m_rid  AXI4 R master; m_rid is ignored
- err_orphan  out  1  sticky: an R beat arrived with no burst outstanding

## Operation
- Arbitration: rotating priority. The requester after the last granted one has the highest priority. After reset, requester 0 has the highest priority.
- Accept condition, evaluated each cycle:
  - at least one s_arvalid is high;
  - the AR slot is free, i.e. !m_arvalid || m_arready;
  - outstanding count < MAXOUT (registered count; no same-cycle bypass from a pop).
- On accept:
  - s_arready[winner] is high for exactly that cycle;
  - the winner's AR fields are latched into the m_ar* registers and m_arvalid is set;
  - the winner index is pushed into the order FIFO;
  - the priority pointer advances past the winner.
- m_ar* fields stay stable while m_arvalid && !m_arready.
- R routing: the head of the order FIFO selects requester h.
  - s_rvalid[h] = m_rvalid && !empty; all other s_rvalid bits are 0.
  - m_rready = s_rready[h] && !empty.
  - m_rdata, m_rresp and m_rlast pass straight through.
- Pop the order FIFO on m_rvalid && m_rready && m_rlast.
- Push and pop in the same cycle: count is unchanged.
- Empty FIFO with m_rvalid high: m_rready = 0 (the beat is stalled, not dropped), and err_orphan sets and holds until reset.
- Outstanding count range is 0..MAXOUT. Its width is clog2(MAXOUT)+1. FIFO pointers wrap modulo MAXOUT.

## Timing
- Reset values: m_arvalid=0, all m_ar* fields=0, s_arready=0, s_rvalid=0, m_rready=0, err_orphan=0, FIFO empty, count=0, priority pointer at 0.
- AR latency: 1 cycle from the s_arready handshake to m_arvalid. Back-to-back accepts are possible every cycle while m_arready=1 and count<MAXOUT.
- R path: combinational, 0-cycle latency. The first R beat of a burst may arrive the cycle after its AR handshake.
- s_arready is combinational from s_arvalid, m_arvalid, m_arready and count. Requesters must not make s_arvalid depend on s_arready.
- Reset asserted mid-burst: all state clears immediately. Any in-flight bursts are abandoned; the system must reset the memory side as well.

## Structure
- Shared package mu_axi_pkg: AXI_BURST_INCR and resp encodings, and a clog2 function.
- Sub-module mu_ordfifo: register FIFO, depth MAXOUT, width clog2(NREQ), with full, empty and count outputs.
- Top level: arbiter, AR register stage, R steering.

## Test plan
- Single requester, NREQ=2: req0 issues arlen=3 at 0x1000 -> m_araddr=0x1000 one cycle later; 4 beats reach s_rvalid[0] only; s_rvalid[1] stays 0; count returns to 0 after rlast.
- Both requesters continuously valid, m_arready=1 -> grants alternate 0,1,0,1; the AR handshake order matches the R routing order.
- MAXOUT=4 with R withheld -> exactly 4 grants, then s_arready=0. Completing one burst -> exactly one new grant on the next cycle.
- m_arready held low for 5 cycles -> m_araddr and m_arlen stay stable, no further s_arready, then resume.
- Backpressure: s_rready[1] toggling during req1's burst -> m_rready mirrors it and no beat is lost or duplicated.
- m_rvalid pulsed with nothing outstanding -> m_rready=0 and err_orphan=1 until rst_n goes low. Assert rst_n mid-burst -> all outputs return to their reset values asynchronously.
